// File: rtl/pc_pkg.sv
// Shared types and defaults for the program counter / fetch sequencer.
// PC_PERF_CNT_EN (optional) enables the performance counters in pc_fetch.
package pc_pkg;

    localparam int unsigned PC_W_DEFAULT       = 11;
    localparam int unsigned START_ADDR_DEFAULT = 0;
    localparam int unsigned LUT_IDX_W          = 6;
    localparam int unsigned PERF_W             = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
        return (v == '1) ? v : v + PERF_W'(1);
    endfunction

endpackage

// File: rtl/pc_perf_cnt.sv
// Two saturating 16-bit counters: RUN cycles and non-stalled taken branches.
// Only instantiated when PC_PERF_CNT_EN is defined.
module pc_perf_cnt
    import pc_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cyc_inc,
    input  logic              br_inc,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] branch_cnt
);

    logic [PERF_W-1:0] cyc_q, cyc_d;
    logic [PERF_W-1:0] br_q,  br_d;

    always_comb begin
        cyc_d = cyc_q;
        br_d  = br_q;
        if (clr) begin
            cyc_d = '0;
            br_d  = '0;
        end else begin
            if (cyc_inc) cyc_d = sat_inc(cyc_q);
            if (br_inc)  br_d  = sat_inc(br_q);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q <= '0;
            br_q  <= '0;
        end else begin
            cyc_q <= cyc_d;
            br_q  <= br_d;
        end
    end

    assign cycle_cnt  = cyc_q;
    assign branch_cnt = br_q;

endmodule

// File: rtl/pc_fetch.sv
// Program counter / fetch sequencer with IDLE -> RUN -> DONE lifecycle.
// Define PC_PERF_CNT_EN to add the cycle_cnt / branch_cnt outputs.
module pc_fetch
    import pc_pkg::*;
#(
    parameter int unsigned     PC_W       = PC_W_DEFAULT,
    parameter logic [PC_W-1:0] START_ADDR = PC_W'(START_ADDR_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            stall,
    input  logic            halt,
    input  logic            branch_taken,
    input  logic            jmp,
    input  logic [PC_W-1:0] target,
    output logic [PC_W-1:0] pc,
    output logic            running,
    output logic            done
`ifdef PC_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0] cycle_cnt,
    output logic [PERF_W-1:0] branch_cnt
`endif
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                end
            end
            RUN: begin
                // Priority: stall > halt > taken branch > sequential increment.
                if (stall) begin
                    pc_d = pc_q;
                end else if (halt) begin
                    state_d = DONE;
                end else if (branch_taken) begin
                    pc_d = jmp ? target : pc_q + target;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = START_ADDR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign pc      = pc_q;
    assign running = (state_q == RUN);
    assign done    = (state_q == DONE);

`ifdef PC_PERF_CNT_EN
    logic perf_clr, perf_br;

    assign perf_clr = (state_q != RUN) && start;
    assign perf_br  = running && !stall && !halt && branch_taken;

    pc_perf_cnt u_perf (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (perf_clr),
        .cyc_inc    (running),
        .br_inc     (perf_br),
        .cycle_cnt  (cycle_cnt),
        .branch_cnt (branch_cnt)
    );
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized traffic
// checked against an arithmetic reference model.
module tb_pc_fetch;

    localparam int unsigned W   = 11;
    localparam int unsigned MOD = 1 << W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stall = 1'b0;
    logic         halt = 1'b0;
    logic         branch_taken = 1'b0;
    logic         jmp = 1'b0;
    logic [W-1:0] target = '0;
    logic [W-1:0] pc;
    logic         running;
    logic         done;
`ifdef PC_PERF_CNT_EN
    logic [15:0]  cycle_cnt;
    logic [15:0]  branch_cnt;
`endif

    pc_fetch #(.PC_W(W), .START_ADDR(11'd0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stall        (stall),
        .halt         (halt),
        .branch_taken (branch_taken),
        .jmp          (jmp),
        .target       (target),
        .pc           (pc),
        .running      (running),
        .done         (done)
`ifdef PC_PERF_CNT_EN
        ,
        .cycle_cnt    (cycle_cnt),
        .branch_cnt   (branch_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: plain integers, lifecycle as two flags.
    int unsigned m_pc   = 0;
    bit          m_run  = 0;
    bit          m_done = 0;
    int unsigned m_cyc  = 0;
    int unsigned m_br   = 0;

    task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned sat16(input int unsigned v);
        return (v > 65535) ? 65535 : v;
    endfunction

    task automatic model_edge();
        int off;
        if (m_run) begin
            m_cyc = sat16(m_cyc + 1);
            if (!stall && !halt && branch_taken) m_br = sat16(m_br + 1);
        end
        if (!m_run) begin
            if (start) begin
                m_pc = 0; m_run = 1; m_done = 0; m_cyc = 0; m_br = 0;
            end
        end else if (stall) begin
            // hold
        end else if (halt) begin
            m_run = 0; m_done = 1;
        end else if (branch_taken) begin
            if (jmp) m_pc = int'(target);
            else begin
                off  = (target >= 11'd1024) ? int'(target) - int'(MOD) : int'(target);
                m_pc = int'((int'(m_pc) + off + int'(MOD)) % int'(MOD));
            end
        end else begin
            m_pc = (m_pc + 1) % MOD;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, int'(pc), m_pc);
        check({tag, ".running"}, int'(running), int'(m_run));
        check({tag, ".done"}, int'(done), int'(m_done));
`ifdef PC_PERF_CNT_EN
        check({tag, ".cyc"}, int'(cycle_cnt), m_cyc);
        check({tag, ".br"}, int'(branch_cnt), m_br);
`endif
    endtask

    // One clock: inputs already driven, model advances, outputs sampled 1ns later.
    task automatic step(input string tag, input bit st, input bit sl, input bit hl,
                        input bit tk, input bit jp, input int unsigned tg);
        start = st; stall = sl; halt = hl; branch_taken = tk; jmp = jp; target = W'(tg);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_pc = 0; m_run = 0; m_done = 0; m_cyc = 0; m_br = 0;
        check_all("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Start, then sequential fetch 1,2,3
        step("start", 1, 0, 0, 0, 0, 0);
        check("start.pc0", int'(pc), 0);
        step("seq1", 0, 0, 0, 0, 0, 0);
        step("seq2", 0, 0, 0, 0, 0, 0);
        step("seq3", 0, 0, 0, 0, 0, 0);
        check("seq.pc3", int'(pc), 3);

        // Absolute and negative relative branch
        step("abs10", 0, 0, 0, 1, 1, 10);
        step("abs200", 0, 0, 0, 1, 1, 200);
        check("abs.pc200", int'(pc), 200);
        step("relm2", 0, 0, 0, 1, 0, 11'h7FE);
        check("rel.pc198", int'(pc), 198);

        // Wrap on increment and on relative add
        step("abs2047", 0, 0, 0, 1, 1, 2047);
        step("wrapinc", 0, 0, 0, 0, 0, 0);
        check("wrap.pc0", int'(pc), 0);
        step("abs2045", 0, 0, 0, 1, 1, 2045);
        step("relp5", 0, 0, 0, 1, 0, 5);
        check("wrap.pc2", int'(pc), 2);
        step("self", 0, 0, 0, 1, 0, 0);
        check("self.pc2", int'(pc), 2);

        // Stall dominates halt and branch; then halt; start ignored in RUN
        step("abs7", 0, 0, 0, 1, 1, 7);
        step("stall", 1, 1, 1, 1, 1, 99);
        check("stall.pc7", int'(pc), 7);
        step("halt", 0, 0, 1, 0, 0, 0);
        check("halt.done", int'(done), 1);
        step("donehold", 0, 0, 1, 1, 1, 300);
        check("donehold.pc7", int'(pc), 7);
        step("restart", 1, 0, 0, 0, 0, 0);
        check("restart.run", int'(running), 1);

        // Async reset mid-RUN at pc=50
        step("abs50", 0, 0, 0, 1, 1, 50);
        check("pre_rst.pc50", int'(pc), 50);
        do_reset();
        step("idle_ignore", 0, 0, 1, 1, 1, 77);

`ifdef PC_PERF_CNT_EN
        // 10 RUN cycles, 3 taken branches with one stalled
        step("p_start", 1, 0, 0, 0, 0, 0);
        step("p1", 0, 0, 0, 1, 0, 4);
        step("p2", 0, 0, 0, 0, 0, 0);
        step("p3", 0, 1, 0, 1, 1, 40);
        step("p4", 0, 0, 0, 0, 0, 0);
        step("p5", 0, 0, 0, 1, 1, 20);
        for (int i = 0; i < 5; i++) step("pn", 0, 0, 0, 0, 0, 0);
        check("perf.cyc10", int'(cycle_cnt), 10);
        check("perf.br2", int'(branch_cnt), 2);
        start = 0; stall = 1; halt = 0; branch_taken = 0;
        repeat (65540) @(posedge clk);
        m_cyc = sat16(m_cyc + 65540);
        #1;
        check("perf.sat", int'(cycle_cnt), 32'hFFFF);
        step("perf.sathold", 0, 1, 0, 0, 0, 0);
        step("perf.halt", 0, 0, 1, 0, 0, 0);
        step("perf.donehold", 0, 0, 0, 0, 0, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step("rnd",
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 1) == 1,
                 $urandom_range(0, MOD - 1));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
